// File: rtl/slc3_mem_arbiter.sv
// slc3_mem_arbiter: shares the single SRAM port between CPU (A) and loader (B), one fixed-length access per grant.
// Define SLC3_ARB_ROUND_ROBIN_EN to alternate ties between ports instead of always favouring port A.
module slc3_mem_arbiter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [15:0] a_addr,
  input  logic [15:0] a_wdata,
  output logic        a_done,
  output logic [15:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [15:0] b_addr,
  input  logic [15:0] b_wdata,
  output logic        b_done,
  output logic [15:0] b_rdata,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        mem_ce,
  output logic        mem_oe,
  output logic        mem_we,
  output logic        busy,
  output logic        owner
);
`ifdef SLC3_ARB_ROUND_ROBIN_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, next;
  logic [3:0] count;
  logic we_r, last_owner, grant_b, any_req;
  logic [15:0] addr_r, wdata_r;
  assign any_req = a_req || b_req;
  // B wins alone, or on a tie when round-robin says A went last
  assign grant_b = b_req && (!a_req || (RR_EN && !last_owner));
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) state <= IDLE;
    else state <= next;
  always_comb
    next = (state == IDLE)   ? (any_req ? ACCESS : IDLE) :
           (state == ACCESS) ? ((count == 4'd0) ? DONE : ACCESS) : IDLE;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      count <= 4'd0;
      we_r <= 1'b0;
      addr_r <= 16'h0;
      wdata_r <= 16'h0;
      owner <= 1'b0;
      last_owner <= 1'b1;
      a_rdata <= 16'h0;
      b_rdata <= 16'h0;
    end else begin
      if (state == IDLE && any_req) begin
        owner <= grant_b;
        we_r <= grant_b ? b_we : a_we;
        addr_r <= grant_b ? b_addr : a_addr;
        wdata_r <= grant_b ? b_wdata : a_wdata;
        count <= 4'(WAIT_CYCLES - 1);
      end
      if (state == ACCESS && count != 4'd0) count <= count - 4'd1;
      if (state == ACCESS && count == 4'd0 && !we_r && !owner) a_rdata <= mem_rdata;
      if (state == ACCESS && count == 4'd0 && !we_r && owner) b_rdata <= mem_rdata;
      if (state == DONE) last_owner <= owner;
    end
  always_comb begin
    mem_ce = state == ACCESS;
    mem_oe = mem_ce && !we_r;
    mem_we = mem_ce && we_r;
    mem_addr = mem_ce ? addr_r : 16'h0;
    mem_wdata = mem_ce ? wdata_r : 16'h0;
    busy = state != IDLE;
    a_done = state == DONE && !owner;
    b_done = state == DONE && owner;
  end
endmodule
